// File: rtl/jk_bank_sequencer_if.sv
// jk_bank_sequencer_if: command handshake bundle for the JK bank sequencer.
// Ports (modports):
//   master - drives cmd_valid, cmd, cmd_data, cmd_len; observes cmd_ready
//   slave  - observes cmd_valid, cmd, cmd_data, cmd_len; drives cmd_ready
interface jk_bank_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd;
    logic [WIDTH-1:0] cmd_data;
    logic [LEN_W-1:0] cmd_len;
    modport master (output cmd_valid, cmd, cmd_data, cmd_len, input cmd_ready);
    modport slave  (input cmd_valid, cmd, cmd_data, cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: drives a negedge JK flip-flop bank from CLEAR/LOAD/COUNT commands and checks it.
// Ports:
//   clk       - rising edge for the controller (the bank uses the falling edge)
//   reset     - asynchronous active-low reset
//   cmd_if    - command handshake (slave): cmd_valid/cmd_ready, cmd, cmd_data, cmd_len
//   q_in      - bank q readback
//   j, k      - registered bank J/K inputs
//   ff_reset  - registered bank synchronous reset, active-high
//   busy      - controller is executing or checking
//   done      - one-cycle completion strobe
//   mismatch  - q_in differs from exp_value, qualified by done
//   exp_value - shadow expected bank value
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    jk_bank_sequencer_if.slave   cmd_if,
    input  logic [WIDTH-1:0]     q_in,
    output logic [WIDTH-1:0]     j,
    output logic [WIDTH-1:0]     k,
    output logic                 ff_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 mismatch,
    output logic [WIDTH-1:0]     exp_value
);
    typedef enum logic [1:0] {IDLE, EXEC, CHECK} state_t;
    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_UP    = 2'b10;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d, exp_q, exp_d;
    logic             ff_reset_q, ff_reset_d;
    logic [WIDTH-1:0] t_up, t_dn;

    assign cmd_if.cmd_ready = (state_q == IDLE) & ~ff_reset_q;
    assign j         = j_q;
    assign k         = k_q;
    assign ff_reset  = ff_reset_q;
    assign exp_value = exp_q;
    assign busy      = state_q != IDLE;
    assign done      = state_q == CHECK;
    assign mismatch  = done & (q_in != exp_q);

    always_comb begin
        // Toggle masks: bit i toggles when all lower bits are 1 (up) or 0 (down).
        t_up[0] = 1'b1;
        t_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t_up[i] = t_up[i-1] & q_in[i-1];
            t_dn[i] = t_dn[i-1] & ~q_in[i-1];
        end
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        rem_d      = rem_q;
        j_d        = '0;
        k_d        = '0;
        ff_reset_d = 1'b0;
        exp_d      = exp_q;
        case (state_q)
            IDLE: if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                op_d    = cmd_if.cmd;
                data_d  = cmd_if.cmd_data;
                rem_d   = cmd_if.cmd[1] ? cmd_if.cmd_len : LEN_W'(1);
                state_d = EXEC;
            end
            EXEC: if (rem_q != '0) begin
                rem_d = rem_q - LEN_W'(1);
                case (op_q)
                    OP_CLEAR: begin
                        ff_reset_d = 1'b1;
                        exp_d      = '0;
                    end
                    OP_LOAD: begin
                        j_d   = data_q;
                        k_d   = ~data_q;
                        exp_d = data_q;
                    end
                    OP_UP: begin
                        j_d   = t_up;
                        k_d   = t_up;
                        exp_d = exp_q + WIDTH'(1);
                    end
                    default: begin
                        j_d   = t_dn;
                        k_d   = t_dn;
                        exp_d = exp_q - WIDTH'(1);
                    end
                endcase
            end else begin
                state_d = CHECK;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            data_q     <= '0;
            rem_q      <= '0;
            j_q        <= '0;
            k_q        <= '0;
            ff_reset_q <= 1'b1;
            exp_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            rem_q      <= rem_d;
            j_q        <= j_d;
            k_q        <= k_d;
            ff_reset_q <= ff_reset_d;
            exp_q      <= exp_d;
        end
    end
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer: scoreboard bench with a behavioural negedge JK bank.
module tb_jk_bank_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] q_in, j, k, exp_value, bq = '0;
    logic       ff_reset, busy, done, mismatch;
    logic       flip = 1'b0;
    logic       hold = 1'b0;
    int         tests = 0;
    int         fails = 0;

    typedef struct {logic [3:0] q; logic [3:0] ev; logic mis;} exp_t;
    exp_t sb[$];
    exp_t e;

    jk_bank_sequencer_if #(.WIDTH(4), .LEN_W(4)) cif ();

    jk_bank_sequencer #(.WIDTH(4), .LEN_W(4)) dut (
        .clk(clk), .reset(reset), .cmd_if(cif.slave), .q_in(q_in),
        .j(j), .k(k), .ff_reset(ff_reset), .busy(busy), .done(done),
        .mismatch(mismatch), .exp_value(exp_value)
    );

    always #5 clk = ~clk;

    // Behavioural bank: negedge JK flops with synchronous active-high reset.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            bq[i] <= ff_reset ? 1'b0 : (j[i] & k[i]) ? ~bq[i] : j[i] ? 1'b1 : k[i] ? 1'b0 : bq[i];
    end
    assign q_in = bq ^ {3'b000, flip};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (reset && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending command at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("done_q", 32'(q_in), 32'(e.q));
                chk("done_exp", 32'(exp_value), 32'(e.ev));
                chk("done_mismatch", 32'(mismatch), 32'(e.mis));
            end
        end
    end

    task automatic issue(input logic [1:0] c, input logic [3:0] d, input logic [3:0] l,
                         input logic push, input logic [3:0] eq, input logic [3:0] ev, input logic em);
        int n = 0;
        exp_t x;
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd = c;
        cif.cmd_data = d;
        cif.cmd_len = l;
        while (!cif.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cif.cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 50 cycles");
        end
        x.q = eq;
        x.ev = ev;
        x.mis = em;
        if (push) sb.push_back(x);
        @(posedge clk);
        #1;
        if (!hold) cif.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!cif.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cif.cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got cmd_ready=0 expected 1 within 50 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd = 2'b00;
        cif.cmd_data = 4'h0;
        cif.cmd_len = 4'h0;
        #12;
        chk("rst_ff_reset", 32'(ff_reset), 1);
        chk("rst_ready", 32'(cif.cmd_ready), 0);
        chk("rst_j", 32'(j), 0);
        chk("rst_k", 32'(k), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_exp", 32'(exp_value), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_ff_reset", 32'(ff_reset), 1);
        chk("rel_ready", 32'(cif.cmd_ready), 0);
        @(posedge clk);
        #1;
        chk("rel1_ff_reset", 32'(ff_reset), 0);
        chk("rel1_ready", 32'(cif.cmd_ready), 1);

        // CLEAR
        issue(2'b00, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0);
        chk("clr_e0_ready", 32'(cif.cmd_ready), 0);
        chk("clr_e0_busy", 32'(busy), 1);
        @(posedge clk); #1;
        chk("clr_e1_ff_reset", 32'(ff_reset), 1);
        chk("clr_e1_ready", 32'(cif.cmd_ready), 0);
        @(posedge clk); #1;
        chk("clr_e2_ff_reset", 32'(ff_reset), 0);
        chk("clr_e2_done", 32'(done), 1);
        chk("clr_e2_ready", 32'(cif.cmd_ready), 0);
        @(posedge clk); #1;
        chk("clr_e3_done", 32'(done), 0);
        chk("clr_e3_ready", 32'(cif.cmd_ready), 1);

        // LOAD 1010
        issue(2'b01, 4'b1010, 4'h0, 1'b1, 4'b1010, 4'b1010, 1'b0);
        @(posedge clk); #1;
        chk("ld_j", 32'(j), 32'b1010);
        chk("ld_k", 32'(k), 32'b0101);
        @(posedge clk); #1;
        chk("ld_j_off", 32'(j), 0);
        chk("ld_k_off", 32'(k), 0);
        wait_idle();

        // LOAD 1110, COUNT_UP 3 wraps to 0001
        issue(2'b01, 4'b1110, 4'h0, 1'b1, 4'b1110, 4'b1110, 1'b0);
        wait_idle();
        issue(2'b10, 4'h0, 4'd3, 1'b1, 4'b0001, 4'b0001, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("up_q1", 32'(q_in), 32'b1111);
        @(posedge clk); #1;
        chk("up_q2", 32'(q_in), 32'b0000);
        @(posedge clk); #1;
        chk("up_q3", 32'(q_in), 32'b0001);
        chk("up_done_e4", 32'(done), 1);
        wait_idle();

        // LOAD 0000, COUNT_DOWN 2
        issue(2'b01, 4'b0000, 4'h0, 1'b1, 4'b0000, 4'b0000, 1'b0);
        wait_idle();
        issue(2'b11, 4'h0, 4'd2, 1'b1, 4'b1110, 4'b1110, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("dn_q1", 32'(q_in), 32'b1111);
        @(posedge clk); #1;
        chk("dn_q2", 32'(q_in), 32'b1110);
        chk("dn_done", 32'(done), 1);
        wait_idle();

        // COUNT_UP len 0
        issue(2'b10, 4'h0, 4'd0, 1'b1, 4'b1110, 4'b1110, 1'b0);
        @(posedge clk); #1;
        chk("len0_done_e1", 32'(done), 1);
        chk("len0_j", 32'(j), 0);
        chk("len0_k", 32'(k), 0);
        wait_idle();

        // Back-to-back with cmd_valid held
        hold = 1'b1;
        issue(2'b01, 4'b0101, 4'h0, 1'b1, 4'b0101, 4'b0101, 1'b0);
        hold = 1'b0;
        chk("b2b_busy", 32'(busy), 1);
        issue(2'b01, 4'b0011, 4'h0, 1'b1, 4'b0011, 4'b0011, 1'b0);
        wait_idle();

        // LOAD 1000 with q_in bit0 corrupted through CHECK
        issue(2'b01, 4'b1000, 4'h0, 1'b1, 4'b1001, 4'b1000, 1'b1);
        @(posedge clk); #1;
        flip = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flip = 1'b0;
        wait_idle();

        // Reset during the second step of COUNT_UP 5
        issue(2'b10, 4'h0, 4'd5, 1'b0, 4'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort_j", 32'(j), 0);
        chk("abort_k", 32'(k), 0);
        chk("abort_ff_reset", 32'(ff_reset), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        #1;
        chk("abort_q", 32'(q_in), 0);
        chk("abort_exp", 32'(exp_value), 0);
        reset = 1'b1;
        issue(2'b00, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0);
        wait_idle();

        repeat (2) @(posedge clk);
        #2;
        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
- Command-driven controller for a bank of WIDTH negedge-clocked JK flip-flops with active-high synchronous reset.
- Accepts CLEAR, LOAD, COUNT_UP and COUNT_DOWN commands over a valid/ready handshake.
- Drives the bank's per-bit j/k and shared reset, and reads back bank q.
- Keeps a shadow expected value and checks the bank against it when each command completes.

Parameters:
- WIDTH, 4, number of JK flip-flops in the bank.
- LEN_W, 4, width of the step-count field for count commands.

Ports:
- clk  input  1  clock; controller uses the rising edge, the bank uses the falling edge.
- reset  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  controller can accept a command.
- cmd  input  2  operation: 00 CLEAR, 01 LOAD, 10 COUNT_UP, 11 COUNT_DOWN.
- cmd_data  input  WIDTH  LOAD value; ignored for other ops.
- cmd_len  input  LEN_W  number of count steps; ignored for CLEAR and LOAD.
- q_in  input  WIDTH  bank q outputs.
- j  output  WIDTH  bank J inputs, registered.
- k  output  WIDTH  bank K inputs, registered.
- ff_reset  output  1  bank synchronous reset, active-high, registered.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle completion strobe.
- mismatch  output  1  q_in differs from exp_value; valid only while done=1.
- exp_value  output  WIDTH  shadow expected bank value.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; j=k=0; ff_reset=1; exp_value=0; step counter=0.
  - ff_reset drops to 0 on the first rising edge after reset release.
- cmd_ready = (state==IDLE) & ~ff_reset. It is 0 during reset and for that first cycle after release.
- Accept occurs on a rising edge where cmd_valid & cmd_ready.
  - Latch op, data and len.
  - Set remaining = 1 for CLEAR/LOAD, or cmd_len for counts.
  - Go to EXEC. j=k=0.
- cmd_valid is ignored outside IDLE. No queuing.
- States: IDLE -> EXEC -> CHECK -> IDLE.
- EXEC, on each rising edge with remaining>0, issue one step and decrement remaining:
  - CLEAR: ff_reset=1, j=k=0; exp=0.
  - LOAD: j=data, k=~data; exp=data.
  - COUNT_UP: t[0]=1, t[i]=&q_in[i-1:0]; j=k=t; exp=exp+1 mod 2^WIDTH.
  - COUNT_DOWN: t[0]=1, t[i]=&~q_in[i-1:0]; j=k=t; exp=exp-1 mod 2^WIDTH.
- EXEC, on a rising edge with remaining==0: j=k=0, ff_reset=0, go to CHECK.
- The bank applies each step at the falling edge. The next step computes t from the already-updated q_in, so there is one step per cycle.
- CHECK lasts one cycle:
  - done=1 and mismatch=(q_in!=exp_value), both combinational from state.
  - Next edge returns to IDLE.
- Latency: accept at edge E0; steps issued E1..EN; CHECK entered E(N+1); done high from E(N+1) to E(N+2); cmd_ready high again after E(N+2).
  - CLEAR/LOAD: N=1.
  - Count with cmd_len=0: CHECK entered at E1, no step issued, exp unchanged.
- Wrap-around: counting past all-ones or zero wraps modulo 2^WIDTH in both bank and shadow; no flag.
- Reset mid-operation:
  - Immediate return to IDLE, j=k=0, ff_reset=1.
  - The bank clears at the next falling edge, so exp_value=0 stays consistent.
  - No done strobe for the aborted command.
- busy=1 in EXEC and CHECK.

Test Plan:
- Release reset, send CLEAR -> ff_reset=1 for exactly one cycle after E1; done during E2–E3; q=0000; mismatch=0; cmd_ready=0 from E0 to E3.
- LOAD cmd_data=1010 -> j=1010, k=0101 for one cycle; done with q=1010, exp_value=1010, mismatch=0.
- LOAD 1110 then COUNT_UP len=3 -> q sequence 1111, 0000, 0001 on successive cycles; done at E4; exp_value=0001 (wrap).
- LOAD 0000 then COUNT_DOWN len=2 -> q 1111, 1110; done, mismatch=0. Then COUNT_UP len=0 -> done one cycle after E1, j=k=0 throughout, exp unchanged.
- Hold cmd_valid high continuously with back-to-back LOAD 0101, LOAD 0011 -> second accepted only after first done; only one command active at a time.
- Force q_in bit0 inverted during CHECK of LOAD 1000 -> done=1, mismatch=1.
- Assert reset during the 2nd step of COUNT_UP len=5 -> j=k=0 and ff_reset=1 immediately; no done; q=0000 after release; next CLEAR completes normally.
